// File: rtl/ct_vfalu_dp_wb_merge.sv
// ---------------------------------------------------------------------------
// ct_vfalu_dp_wb_merge: merges N_SRC FALU unit results into one EX3 forward /
// EX1 mfvr stream plus a registered writeback FIFO with sticky flags.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ct_vfalu_dp_wb_merge #(
  parameter int N_SRC  = 2,
  parameter int DATA_W = 64,
  parameter int EREG_W = 5,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       forever_cpuclk,
  input  logic                       cpurst,
  input  logic [N_SRC-1:0]           src_r_vld,
  input  logic [N_SRC*DATA_W-1:0]    src_result,
  input  logic [N_SRC*EREG_W-1:0]    src_ereg,
  input  logic [N_SRC-1:0]           mfvr_sel,
  input  logic [N_SRC*DATA_W-1:0]    src_mfvr_data,
  output logic [DATA_W-1:0]          mfvr_data,
  output logic [DATA_W-1:0]          ex3_freg_data,
  output logic [EREG_W-1:0]          ex3_ereg_data,
  input  logic                       rtu_flush,
  output logic                       wb_vld,
  output logic [DATA_W-1:0]          wb_data,
  output logic [EREG_W-1:0]          wb_ereg,
  input  logic                       wb_ready,
  output logic                       fifo_full,
  output logic [CNT_W-1:0]           fifo_cnt,
  input  logic                       fflags_clr,
  output logic [EREG_W-1:0]          fflags_acc,
  input  logic                       err_clr,
  output logic                       err_multi_hot,
  output logic                       err_overflow
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W+EREG_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [EREG_W-1:0] acc_q, acc_d;
  logic              mh_q, mh_d;
  logic              ovf_q, ovf_d;

  logic push, pop, wr_en, ovf_set, mh_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Lowest index wins: iterate downward so the last assignment is the winner.
  always_comb begin
    ex3_freg_data = '0;
    ex3_ereg_data = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_r_vld[i]) begin
        ex3_freg_data = src_result[i*DATA_W +: DATA_W];
        ex3_ereg_data = src_ereg[i*EREG_W +: EREG_W];
      end
    end
  end

  always_comb begin
    mfvr_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      mfvr_data = mfvr_data | ({DATA_W{mfvr_sel[i]}} & src_mfvr_data[i*DATA_W +: DATA_W]);
    end
  end

  assign fifo_full = (cnt_q == CNT_FULL);
  assign wb_vld    = (cnt_q != '0);
  assign fifo_cnt  = cnt_q;
  assign {wb_data, wb_ereg} = mem[rd_ptr_q];

  assign push    = (|src_r_vld) & ~rtu_flush;
  assign pop     = wb_vld & wb_ready & ~rtu_flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en   = push & (~fifo_full | pop);
  assign ovf_set = push & fifo_full & ~pop;
  assign mh_set  = (src_r_vld & (src_r_vld - N_SRC'(1))) != '0;

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rtu_flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_en && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!wr_en && pop) cnt_d = cnt_q - CNT_W'(1);
    end
    acc_d = (fflags_clr ? '0 : acc_q) | (push ? ex3_ereg_data : '0);
    mh_d  = mh_set  | (mh_q  & ~err_clr);
    ovf_d = ovf_set | (ovf_q & ~err_clr);
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      acc_q    <= '0;
      mh_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      acc_q    <= acc_d;
      mh_q     <= mh_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (wr_en) mem[wr_ptr_q] <= {ex3_freg_data, ex3_ereg_data};
  end

  assign fflags_acc    = acc_q;
  assign err_multi_hot = mh_q;
  assign err_overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ct_vfalu_dp_wb_merge.sv
// ---------------------------------------------------------------------------
// tb_ct_vfalu_dp_wb_merge: vector table, directed sequences and random
// traffic checked against a queue-based reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ct_vfalu_dp_wb_merge;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   src_r_vld;
  logic [127:0] src_result;
  logic [9:0]   src_ereg;
  logic [1:0]   mfvr_sel;
  logic [127:0] src_mfvr_data;
  logic [63:0]  mfvr_data, ex3_freg_data, wb_data;
  logic [4:0]   ex3_ereg_data, wb_ereg, fflags_acc;
  logic         rtu_flush, wb_vld, wb_ready, fifo_full, fflags_clr, err_clr;
  logic         err_multi_hot, err_overflow;
  logic [1:0]   fifo_cnt;

  ct_vfalu_dp_wb_merge #(.N_SRC(2), .DATA_W(64), .EREG_W(5), .DEPTH(DEPTH)) dut (
    .forever_cpuclk(clk), .cpurst(rst),
    .src_r_vld(src_r_vld), .src_result(src_result), .src_ereg(src_ereg),
    .mfvr_sel(mfvr_sel), .src_mfvr_data(src_mfvr_data), .mfvr_data(mfvr_data),
    .ex3_freg_data(ex3_freg_data), .ex3_ereg_data(ex3_ereg_data),
    .rtu_flush(rtu_flush), .wb_vld(wb_vld), .wb_data(wb_data), .wb_ereg(wb_ereg),
    .wb_ready(wb_ready), .fifo_full(fifo_full), .fifo_cnt(fifo_cnt),
    .fflags_clr(fflags_clr), .fflags_acc(fflags_acc), .err_clr(err_clr),
    .err_multi_hot(err_multi_hot), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  // Reference model
  typedef struct packed { logic [63:0] d; logic [4:0] e; } ent_t;
  ent_t       q[$];
  logic [4:0] m_acc;
  logic       m_mh, m_ovf;

  task automatic model_reset();
    q.delete();
    m_acc = '0; m_mh = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".cnt"},  64'(fifo_cnt), 64'(q.size()));
    chk({tag, ".vld"},  64'(wb_vld), 64'(q.size() != 0));
    chk({tag, ".full"}, 64'(fifo_full), 64'(q.size() == DEPTH));
    if (q.size() != 0) begin
      chk({tag, ".wb_data"}, wb_data, q[0].d);
      chk({tag, ".wb_ereg"}, 64'(wb_ereg), 64'(q[0].e));
    end
    chk({tag, ".acc"}, 64'(fflags_acc), 64'(m_acc));
    chk({tag, ".mh"},  64'(err_multi_hot), 64'(m_mh));
    chk({tag, ".ovf"}, 64'(err_overflow), 64'(m_ovf));
  endtask

  // One clock: called at posedge+1, returns at next posedge+1.
  task automatic cycle(input logic [1:0] vld, input logic [63:0] r0, input logic [63:0] r1,
                       input logic [4:0] e0, input logic [4:0] e1, input logic flush,
                       input logic ready, input logic fclr, input logic eclr);
    logic [63:0] sd;
    logic [4:0]  se;
    logic        push, pop, full_b;
    src_r_vld = vld; src_result = {r1, r0}; src_ereg = {e1, e0};
    rtu_flush = flush; wb_ready = ready; fflags_clr = fclr; err_clr = eclr;
    #1;
    if (vld[0])      begin sd = r0; se = e0; end
    else if (vld[1]) begin sd = r1; se = e1; end
    else             begin sd = '0; se = '0; end
    chk("ex3_freg", ex3_freg_data, sd);
    chk("ex3_ereg", 64'(ex3_ereg_data), 64'(se));
    full_b = (q.size() == DEPTH);
    push   = (vld != 0) && !flush;
    pop    = (q.size() != 0) && ready && !flush;
    m_acc  = (fclr ? 5'd0 : m_acc) | (push ? se : 5'd0);
    m_mh   = (vld == 2'b11) | (m_mh & ~eclr);
    m_ovf  = (push && full_b && !pop) | (m_ovf & ~eclr);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push && (!full_b || pop)) q.push_back('{d: sd, e: se});
    end
    @(posedge clk); #1;
    check_state("cyc");
  endtask

  task automatic idle(input logic ready);
    cycle(2'b00, 64'h0, 64'h0, 5'h0, 5'h0, 1'b0, ready, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [63:0] d, input logic [4:0] e, input logic ready);
    cycle(2'b01, d, 64'h0, e, 5'h0, 1'b0, ready, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [63:0] r0, r1;
    logic [4:0]  e0, e1;
    logic [1:0]  msel;
    logic [63:0] m0, m1;
    logic [63:0] x_mfvr, x_freg;
    logic [4:0]  x_ereg;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [4:0] acc_save;

    tbl[0] = '{2'b00, 64'h1, 64'h2, 5'h1, 5'h2, 2'b00, 64'h55, 64'hAA, 64'h0, 64'h0, 5'h0};
    tbl[1] = '{2'b01, 64'h11, 64'h22, 5'h1, 5'h2, 2'b01, 64'h55, 64'hAA, 64'h55, 64'h11, 5'h1};
    tbl[2] = '{2'b10, 64'h11, 64'hDEAD_BEEF_0000_0001, 5'h1, 5'b00100, 2'b10, 64'h55, 64'hAA,
               64'hAA, 64'hDEAD_BEEF_0000_0001, 5'b00100};
    tbl[3] = '{2'b11, 64'h1, 64'h2, 5'h3, 5'h10, 2'b11, 64'h55, 64'hAA, 64'hFF, 64'h1, 5'h3};
    tbl[4] = '{2'b00, 64'h7, 64'h8, 5'h7, 5'h8, 2'b00, 64'h55, 64'hAA, 64'h0, 64'h0, 5'h0};
    tbl[5] = '{2'b10, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 5'h7, 5'h1F, 2'b01,
               64'h0123_4567_89AB_CDEF, 64'hAA, 64'h0123_4567_89AB_CDEF,
               64'hFFFF_FFFF_FFFF_FFFF, 5'h1F};

    rst = 1'b1;
    src_r_vld = '0; src_result = '0; src_ereg = '0; mfvr_sel = '0; src_mfvr_data = '0;
    rtu_flush = 1'b0; wb_ready = 1'b0; fflags_clr = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk); #1;
    check_state("reset");

    // Combinational table: flush held so no state changes, all within one cycle.
    rtu_flush = 1'b1;
    foreach (tbl[i]) begin
      src_r_vld = tbl[i].vld; src_result = {tbl[i].r1, tbl[i].r0}; src_ereg = {tbl[i].e1, tbl[i].e0};
      mfvr_sel = tbl[i].msel; src_mfvr_data = {tbl[i].m1, tbl[i].m0};
      #1;
      chk($sformatf("tbl%0d.mfvr", i), mfvr_data, tbl[i].x_mfvr);
      chk($sformatf("tbl%0d.freg", i), ex3_freg_data, tbl[i].x_freg);
      chk($sformatf("tbl%0d.ereg", i), 64'(ex3_ereg_data), 64'(tbl[i].x_ereg));
    end
    src_r_vld = '0; rtu_flush = 1'b0;
    @(posedge clk); #1;

    // Single push from source 1
    cycle(2'b10, 64'h0, 64'hDEAD_BEEF_0000_0001, 5'h0, 5'b00100, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s1.wb_vld", 64'(wb_vld), 64'h1);
    chk("s1.wb_data", wb_data, 64'hDEAD_BEEF_0000_0001);
    chk("s1.wb_ereg", 64'(wb_ereg), 64'h4);
    chk("s1.acc", 64'(fflags_acc), 64'h4);
    idle(1'b1);

    // Multi-hot: source 0 wins, sticky until err_clr
    cycle(2'b11, 64'h1, 64'h2, 5'h0, 5'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mh.wb_data", wb_data, 64'h1);
    chk("mh.set", 64'(err_multi_hot), 64'h1);
    idle(1'b1); idle(1'b1);
    chk("mh.sticky", 64'(err_multi_hot), 64'h1);
    cycle(2'b00, 64'h0, 64'h0, 5'h0, 5'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("mh.clr", 64'(err_multi_hot), 64'h0);

    // Overflow: A, B fill, C dropped
    push1(64'hA, 5'h1, 1'b0);
    push1(64'hB, 5'h2, 1'b0);
    chk("ovf.full", 64'(fifo_full), 64'h1);
    push1(64'hC, 5'h4, 1'b0);
    chk("ovf.set", 64'(err_overflow), 64'h1);
    chk("ovf.headA", wb_data, 64'hA);
    idle(1'b1);
    chk("ovf.headB", wb_data, 64'hB);
    idle(1'b1);
    chk("ovf.empty", 64'(wb_vld), 64'h0);
    cycle(2'b00, 64'h0, 64'h0, 5'h0, 5'h0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Full with simultaneous push and pop
    push1(64'hA, 5'h0, 1'b0);
    push1(64'hB, 5'h0, 1'b0);
    push1(64'hD, 5'h8, 1'b1);
    chk("pp.cnt", 64'(fifo_cnt), 64'h2);
    chk("pp.ovf", 64'(err_overflow), 64'h0);
    chk("pp.headB", wb_data, 64'hB);
    idle(1'b1);
    chk("pp.headD", wb_data, 64'hD);
    idle(1'b1);

    // Flush with push
    push1(64'h10, 5'h0, 1'b0);
    push1(64'h20, 5'h0, 1'b0);
    acc_save = m_acc;
    cycle(2'b01, 64'h30, 64'h0, 5'h10, 5'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fl.cnt", 64'(fifo_cnt), 64'h0);
    chk("fl.vld", 64'(wb_vld), 64'h0);
    chk("fl.acc", 64'(fflags_acc), 64'(acc_save));

    // Clear and push together keeps only the new flags
    cycle(2'b01, 64'h40, 64'h0, 5'h2, 5'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clrpush.acc", 64'(fflags_acc), 64'h2);
    idle(1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0] v;
      v = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      cycle(v, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 5'($urandom),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 11) == 0));
    end

    // Async reset mid-stream
    cycle(2'b11, 64'h5, 64'h6, 5'h3, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push1(64'h7, 5'h1, 1'b0);
    src_r_vld = '0; wb_ready = 1'b0; fflags_clr = 1'b0; err_clr = 1'b0; rtu_flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst.cnt", 64'(fifo_cnt), 64'h0);
    chk("rst.vld", 64'(wb_vld), 64'h0);
    chk("rst.full", 64'(fifo_full), 64'h0);
    chk("rst.acc", 64'(fflags_acc), 64'h0);
    chk("rst.mh", 64'(err_multi_hot), 64'h0);
    chk("rst.ovf", 64'(err_overflow), 64'h0);
    model_reset();
    @(posedge clk); #4 rst = 1'b0;
    @(posedge clk); #1;
    push1(64'h99, 5'h8, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
